// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing controller for the FIR engine (handshake, circular buffer, MAC schedule, stream I/O)
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  input  logic                   ap_done_clr,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   cfg_tap_gnt,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);
  localparam int IW = $clog2(Tape_Num + 1);
  localparam logic [IW-1:0] LAST = IW'(Tape_Num - 1);
  localparam logic [IW-1:0] NTAP = IW'(Tape_Num);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, MAC, OUT} state_t;
  state_t state, next;
  logic [IW-1:0] idx, head, didx;
  logic [31:0] cnt, len;
  logic [pDATA_WIDTH-1:0] acc;
  logic signed [pDATA_WIDTH-1:0] prod;
  logic go, last, set_done, unused;
  function automatic logic [pADDR_WIDTH-1:0] addr(input logic [IW-1:0] i);
    return pADDR_WIDTH'({i, 2'b00});
  endfunction
  assign go = state == IDLE && ap_start && |data_length;
  assign last = cnt == len;
  assign set_done = (state == IDLE && ap_start && ~|data_length) || (state == OUT && sm_tready && last);
  assign didx = head >= idx ? head - idx : head + NTAP - idx;
  assign prod = $signed(tap_Do) * $signed(data_Do);
  assign cfg_tap_gnt = ap_idle;
  assign sm_tlast = state == OUT && last;
  assign sm_tdata = state == OUT ? acc : '0;
  assign unused = ss_tlast;
  // state register; async reset aborts any run in progress
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) state <= IDLE;
    else state <= next;
  // next-state and RAM/stream strobes, all decoded from the current state
  always_comb begin
    next = state;
    ap_idle = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    tap_EN = 1'b0;
    tap_A = '0;
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A = '0;
    data_Di = '0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        next = go ? CLEAR : IDLE;
      end
      CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A = addr(idx);
        next = idx == LAST ? WAIT_IN : CLEAR;
      end
      WAIT_IN: begin
        ss_tready = 1'b1;
        data_EN = ss_tvalid;
        data_WE = ss_tvalid ? 4'hF : 4'h0;
        data_A = addr(head);
        data_Di = ss_tdata;
        next = ss_tvalid ? MAC : WAIT_IN;
      end
      MAC: begin
        tap_EN = idx <= LAST;
        data_EN = idx <= LAST;
        tap_A = idx <= LAST ? addr(idx) : '0;
        data_A = idx <= LAST ? addr(didx) : '0;
        next = idx == NTAP ? OUT : MAC;
      end
      OUT: begin
        sm_tvalid = 1'b1;
        next = sm_tready ? (last ? IDLE : WAIT_IN) : OUT;
      end
      default: next = IDLE;
    endcase
  end
  // datapath: step counter, buffer head, sample count, accumulator and sticky done
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) begin
      idx <= '0;
      head <= '0;
      cnt <= '0;
      len <= '0;
      acc <= '0;
      ap_done <= 1'b0;
    end else begin
      idx <= (next == state && (state == CLEAR || state == MAC)) ? idx + 1'b1 : '0;
      if (go) begin
        cnt <= '0;
        head <= '0;
        len <= data_length;
      end
      if (state == WAIT_IN && ss_tvalid) begin
        cnt <= cnt + 1;
        acc <= '0;
      end
      if (state == MAC && idx != 0) acc <= acc + prod;
      if (state == OUT && sm_tready) head <= head == LAST ? '0 : head + 1'b1;
      ap_done <= set_done ? 1'b1 : (go || ap_done_clr) ? 1'b0 : ap_done;
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed self-checking bench for fir_ctrl with behavioural tap/data BRAMs
module tb_fir_ctrl;
  logic clk = 0, rst = 1;
  logic ap_start = 0, ap_done_clr = 0, ap_done, ap_idle, cfg_tap_gnt;
  logic [31:0] data_length = 0;
  logic [31:0] ss_tdata = 0, sm_tdata, tap_Do = 0, data_Do = 0, data_Di;
  logic ss_tvalid = 0, ss_tready, ss_tlast = 0, sm_tvalid, sm_tready = 0, sm_tlast;
  logic tap_EN, data_EN;
  logic [3:0] data_WE;
  logic [11:0] tap_A, data_A;
  int tap_mem[11], dat_mem[11];
  int in_v[16], exp_v[16];
  int checks = 0, failures = 0;
  int h[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  fir_ctrl dut (
    .axis_clk(clk), .axis_rst(rst), .ap_start(ap_start), .data_length(data_length),
    .ap_done_clr(ap_done_clr), .ap_done(ap_done), .ap_idle(ap_idle), .cfg_tap_gnt(cfg_tap_gnt),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
    .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];

  always @(posedge clk)
    if (data_EN) begin
      if (data_WE == 4'hF) begin
        dat_mem[data_A[5:2]] <= data_Di;
        data_Do <= data_Di;
      end else data_Do <= dat_mem[data_A[5:2]];
    end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input int stall_at, input int poke_at);
    int c;
    logic bad;
    logic [31:0] held;
    ap_start = 1; data_length = n;
    tick;
    ap_start = 0; data_length = 0;
    checks++;
    if (ap_idle !== 0 || cfg_tap_gnt !== 0) begin
      failures++;
      $display("FAIL start_idle got idle=%b gnt=%b exp idle=0 gnt=0", ap_idle, cfg_tap_gnt);
    end
    c = 1;
    while (ss_tready !== 1 && c < 40) begin
      tick;
      c++;
    end
    checks++;
    if (c !== 12) begin
      failures++;
      $display("FAIL clear_latency got=%0d exp=12", c);
    end
    for (int i = 0; i < n; i++) begin
      ss_tvalid = 1; ss_tdata = in_v[i];
      tick;
      ss_tvalid = 0;
      c = 1;
      bad = 0;
      while (sm_tvalid !== 1 && c < 40) begin
        if (ss_tready !== 0 || cfg_tap_gnt !== 0) bad = 1;
        if (c == poke_at) begin
          ap_start = 1; data_length = 1;
        end
        tick;
        ap_start = 0; data_length = 0;
        c++;
      end
      checks++;
      if (c !== 13 || bad) begin
        failures++;
        $display("FAIL mac_latency s%0d got=%0d bad=%b exp=13 bad=0", i, c, bad);
      end
      checks++;
      if (sm_tdata !== 32'(exp_v[i])) begin
        failures++;
        $display("FAIL out_data s%0d got=%0d exp=%0d", i, $signed(sm_tdata), exp_v[i]);
      end
      checks++;
      if (sm_tlast !== (i == n - 1)) begin
        failures++;
        $display("FAIL out_last s%0d got=%b exp=%b", i, sm_tlast, i == n - 1);
      end
      if (i == stall_at) begin
        held = sm_tdata;
        bad = 0;
        repeat (20) begin
          tick;
          if (sm_tvalid !== 1 || sm_tdata !== held || ss_tready !== 0 || cfg_tap_gnt !== 0) bad = 1;
        end
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL backpressure_hold s%0d got unstable exp stable", i);
        end
      end
      sm_tready = 1;
      tick;
      sm_tready = 0;
      if (i == n - 1) begin
        checks++;
        if (ap_done !== 1 || ap_idle !== 1 || cfg_tap_gnt !== 1 || sm_tvalid !== 0) begin
          failures++;
          $display("FAIL run_done got done=%b idle=%b gnt=%b vld=%b exp 1 1 1 0", ap_done, ap_idle, cfg_tap_gnt, sm_tvalid);
        end
      end else begin
        checks++;
        if (ss_tready !== 1 || sm_tvalid !== 0) begin
          failures++;
          $display("FAIL next_ready s%0d got rdy=%b vld=%b exp rdy=1 vld=0", i, ss_tready, sm_tvalid);
        end
      end
    end
  endtask

  task automatic load_impulse;
    for (int k = 0; k < 11; k++) begin
      tap_mem[k] = h[k];
      in_v[k] = (k == 0) ? 1 : 0;
      exp_v[k] = h[k];
    end
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    checks++;
    if (ap_idle !== 1 || ap_done !== 0 || cfg_tap_gnt !== 1 || ss_tready !== 0) begin
      failures++;
      $display("FAIL reset_ctrl got idle=%b done=%b gnt=%b rdy=%b exp 1 0 1 0", ap_idle, ap_done, cfg_tap_gnt, ss_tready);
    end
    checks++;
    if (sm_tvalid !== 0 || sm_tlast !== 0 || sm_tdata !== 0 || tap_EN !== 0 || data_EN !== 0 ||
        data_WE !== 0 || tap_A !== 0 || data_A !== 0 || data_Di !== 0) begin
      failures++;
      $display("FAIL reset_bus got vld=%b last=%b data=%0d ten=%b den=%b we=%h exp all 0", sm_tvalid, sm_tlast, sm_tdata, tap_EN, data_EN, data_WE);
    end
    rst = 0;
    tick;
  endtask

  task automatic test_impulse;
    load_impulse();
    run_stream(11, -1, -1);
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 11; k++) tap_mem[k] = 1;
    for (int k = 0; k < 15; k++) begin
      in_v[k] = 1;
      exp_v[k] = (k < 11) ? k + 1 : 11;
    end
    run_stream(15, -1, -1);
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 11; k++) tap_mem[k] = h[k];
    in_v[0] = 3; in_v[1] = -2; in_v[2] = 7;
    exp_v[0] = 0; exp_v[1] = -30; exp_v[2] = -7;
    run_stream(3, 1, -1);
  endtask

  task automatic test_control;
    in_v[0] = 5; in_v[1] = 1;
    exp_v[0] = 0; exp_v[1] = -50;
    run_stream(2, -1, 5);
    ap_done_clr = 1;
    tick;
    ap_done_clr = 0;
    checks++;
    if (ap_done !== 0) begin
      failures++;
      $display("FAIL done_clr got=%b exp=0", ap_done);
    end
    ap_start = 1; data_length = 0;
    tick;
    ap_start = 0;
    checks++;
    if (ap_done !== 1 || ap_idle !== 1 || ss_tready !== 0 || cfg_tap_gnt !== 1) begin
      failures++;
      $display("FAIL zero_len got done=%b idle=%b rdy=%b gnt=%b exp 1 1 0 1", ap_done, ap_idle, ss_tready, cfg_tap_gnt);
    end
    ap_start = 1; ap_done_clr = 1;
    tick;
    ap_start = 0; ap_done_clr = 0;
    checks++;
    if (ap_done !== 1) begin
      failures++;
      $display("FAIL set_wins got=%b exp=1", ap_done);
    end
    ap_done_clr = 1;
    tick;
    ap_done_clr = 0;
    checks++;
    if (ap_done !== 0) begin
      failures++;
      $display("FAIL done_clr2 got=%b exp=0", ap_done);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    load_impulse();
    ap_start = 1; data_length = 11;
    tick;
    ap_start = 0; data_length = 0;
    c = 0;
    while (ss_tready !== 1 && c < 40) begin
      tick;
      c++;
    end
    checks++;
    if (ss_tready !== 1) begin
      failures++;
      $display("FAIL mid_ready got=%b exp=1", ss_tready);
    end
    ss_tvalid = 1; ss_tdata = 1;
    tick;
    ss_tvalid = 0;
    repeat (5) tick;
    rst = 1;
    #1;
    checks++;
    if (ap_idle !== 1 || sm_tvalid !== 0 || tap_EN !== 0 || data_EN !== 0 || cfg_tap_gnt !== 1) begin
      failures++;
      $display("FAIL mid_reset got idle=%b vld=%b ten=%b den=%b gnt=%b exp 1 0 0 0 1", ap_idle, sm_tvalid, tap_EN, data_EN, cfg_tap_gnt);
    end
    tick;
    rst = 0;
    tick;
    run_stream(11, -1, -1);
  endtask

  initial begin
    tick;
    test_reset();
    test_impulse();
    test_wrap();
    test_backpressure();
    test_control();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
